// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts word-aligned fetch addresses and returns
// the preloaded instruction word after a fixed latency over a valid/ready channel.
module imem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     i_clk_w,
  input  logic                     i_rst_n_w,
  input  logic                     i_req_valid_w,
  output logic                     o_req_ready_w,
  input  logic [31:0]              i_req_addr_w,
  output logic                     o_rsp_valid_w,
  input  logic                     i_rsp_ready_w,
  output logic [31:0]              o_rsp_data_w,
  output logic [31:0]              o_rsp_addr_w,
  output logic                     o_rsp_err_w,
  input  logic                     i_flush_w,
  input  logic                     i_ld_en_w,
  input  logic [$clog2(DEPTH)-1:0] i_ld_idx_w,
  input  logic [31:0]              i_ld_data_w
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   addr_q;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_data;
  logic          cap_err;
  logic          accept;
  logic          capture;

  logic [31:0]   mem [DEPTH];

  assign o_req_ready_w = (state == IDLE) && !i_flush_w;
  assign o_rsp_valid_w = (state == RESP);

  // With a single-cycle latency the response is captured on the accept edge,
  // straight from the request address.
  assign cap_addr = (LATENCY == 1) ? i_req_addr_w : addr_q;
  assign cap_err  = (cap_addr[1:0] != 2'b00) || ({2'b00, cap_addr[31:2]} >= DEPTH);
  assign cap_data = cap_err ? '0 : mem[cap_addr[2 +: IW]];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req_valid_w) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            capture   = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CW'(LATENCY - 1);
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready_w) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush outranks both the response handshake and request acceptance.
    if (i_flush_w) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      accept    = 1'b0;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge i_clk_w or negedge i_rst_n_w) begin
    if (!i_rst_n_w) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      o_rsp_data_w <= '0;
      o_rsp_addr_w <= '0;
      o_rsp_err_w  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) addr_q <= i_req_addr_w;
      if (capture) begin
        o_rsp_data_w <= cap_data;
        o_rsp_addr_w <= cap_addr;
        o_rsp_err_w  <= cap_err;
      end
    end
  end

  // Array is deliberately unreset so preloaded code survives a reset.
  always_ff @(posedge i_clk_w) begin
    if (i_ld_en_w) mem[i_ld_idx_w] <= i_ld_data_w;
  end

endmodule
